// File: rtl/ttt_pkg.sv
// ttt_pkg: shared encodings for the tic-tac-toe game sequencer.
//   - cell, turn and winner encodings
//   - sequencer FSM state enum
//   - WIN_LINES: the 8 winning lines as triples of cell indices
//   - BOARD_W: board width (9 cells x 2 bits)
package ttt_pkg;

   localparam int unsigned BOARD_W = 18;
   localparam int unsigned NUM_CELLS = 9;

   // Cell contents
   localparam logic [1:0] CELL_EMPTY  = 2'b00;
   localparam logic [1:0] CELL_AGENT  = 2'b01;
   localparam logic [1:0] CELL_PLAYER = 2'b10;

   // Whose turn it is
   localparam logic [1:0] TURN_NONE   = 2'b00;
   localparam logic [1:0] TURN_AGENT  = 2'b01;
   localparam logic [1:0] TURN_PLAYER = 2'b10;

   // Game result
   localparam logic [1:0] WIN_DRAW   = 2'b00;
   localparam logic [1:0] WIN_AGENT  = 2'b01;
   localparam logic [1:0] WIN_PLAYER = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StAgentWait,
      StUserWait,
      StCheck,
      StDone
   } ttt_state_e;

   // Rows, columns, diagonals. Order inside a triple is irrelevant.
   localparam logic [7:0][2:0][3:0] WIN_LINES = '{
      '{4'd2, 4'd4, 4'd6},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd5, 4'd8},
      '{4'd1, 4'd4, 4'd7},
      '{4'd0, 4'd3, 4'd6},
      '{4'd6, 4'd7, 4'd8},
      '{4'd3, 4'd4, 4'd5},
      '{4'd0, 4'd1, 4'd2}
   };

   // Contents of cell idx; callers guarantee idx < NUM_CELLS.
   function automatic logic [1:0] cell_at(input logic [BOARD_W-1:0] board,
                                          input logic [3:0] idx);
      return board[2*idx +: 2];
   endfunction

   // A move is legal when it names a real cell that is still empty.
   function automatic logic move_legal(input logic [BOARD_W-1:0] board,
                                       input logic [3:0] idx);
      logic ok;
      ok = 1'b0;
      if (idx < 4'(NUM_CELLS)) begin
         ok = (cell_at(board, idx) == CELL_EMPTY);
      end
      return ok;
   endfunction

endpackage

// File: rtl/ttt_win_checker.sv
// ttt_win_checker: combinational three-in-a-row detector.
// Ports:
//   board [17:0] in  - board, cell i = bits [2i+1:2i]
//   mark  [1:0]  in  - mark to test (CELL_AGENT or CELL_PLAYER)
//   win          out - 1 when any of the 8 lines is filled with mark
module ttt_win_checker
   import ttt_pkg::*;
(
   input  logic [BOARD_W-1:0] board,
   input  logic [1:0]         mark,
   output logic               win
);

   always_comb begin
      win = 1'b0;
      for (int l = 0; l < 8; l++) begin
         if (cell_at(board, WIN_LINES[l][0]) == mark &&
             cell_at(board, WIN_LINES[l][1]) == mark &&
             cell_at(board, WIN_LINES[l][2]) == mark &&
             mark != CELL_EMPTY) begin
            win = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ttt_game_sequencer.sv
// ttt_game_sequencer: turn sequencer for one tic-tac-toe game, agent vs user.
// Owns the board and grants the single write path to one requester at a time;
// rejects illegal moves and detects win/draw after every applied move.
// Optional build macro: MOVE_TIMEOUT_EN enables a per-move time limit of
// TIMEOUT_CYCLES wait cycles; the idle mover forfeits when it expires.
// Ports:
//   clock, rst (sync, active-high)
//   start                     - new game, honoured in IDLE/DONE only
//   agent_req/valid/action    - agent move handshake
//   user_ready/valid/action   - user move handshake
//   state_output [17:0]       - board
//   action_output [3:0]       - last accepted action
//   turn [1:0]                - 01 agent, 10 player, 00 none
//   move_count [3:0]          - accepted moves 0..9
//   illegal                   - one-cycle pulse after a rejected move
//   game_over, winner, timeout- result, valid in DONE
module ttt_game_sequencer
   import ttt_pkg::*;
#(
   parameter bit          AGENT_FIRST    = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic               clock,
   input  logic               rst,
   input  logic               start,
   output logic               agent_req,
   input  logic               agent_valid,
   input  logic [3:0]         agent_action,
   output logic               user_ready,
   input  logic               user_valid,
   input  logic [3:0]         user_action,
   output logic [BOARD_W-1:0] state_output,
   output logic [3:0]         action_output,
   output logic [1:0]         turn,
   output logic [3:0]         move_count,
   output logic               illegal,
   output logic               game_over,
   output logic [1:0]         winner,
   output logic               timeout
);

   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..255");
   end

   ttt_state_e         state_q, state_d;
   logic [BOARD_W-1:0] board_q, board_d;
   logic [3:0]         action_q, action_d;
   logic [3:0]         count_q, count_d;
   logic [1:0]         winner_q, winner_d;
   logic               illegal_q, illegal_d;
   // 1 when the agent made the most recent accepted move
   logic               agent_moved_q, agent_moved_d;
   logic [1:0]         mover_mark;
   logic               mover_wins;

`ifdef MOVE_TIMEOUT_EN
   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       timeout_q, timeout_d;
`endif

   assign mover_mark = agent_moved_q ? CELL_AGENT : CELL_PLAYER;

   ttt_win_checker u_win_checker (
      .board (board_q),
      .mark  (mover_mark),
      .win   (mover_wins)
   );

   always_comb begin
      state_d       = state_q;
      board_d       = board_q;
      action_d      = action_q;
      count_d       = count_q;
      winner_d      = winner_q;
      agent_moved_d = agent_moved_q;
      illegal_d     = 1'b0;
`ifdef MOVE_TIMEOUT_EN
      timeout_d  = timeout_q;
      // Counts only while waiting; any entry into a WAIT state starts from 0.
      wait_cnt_d = (state_q == StAgentWait || state_q == StUserWait) ?
                   wait_cnt_q + 8'd1 : 8'd0;
`endif

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               board_d  = '0;
               count_d  = '0;
               winner_d = WIN_DRAW;
`ifdef MOVE_TIMEOUT_EN
               timeout_d = 1'b0;
`endif
               state_d  = AGENT_FIRST ? StAgentWait : StUserWait;
            end
         end
         StAgentWait: begin
            if (agent_valid && move_legal(board_q, agent_action)) begin
               board_d[2*agent_action +: 2] = CELL_AGENT;
               action_d      = agent_action;
               count_d       = count_q + 4'd1;
               agent_moved_d = 1'b1;
               state_d       = StCheck;
            end else begin
               illegal_d = agent_valid;
`ifdef MOVE_TIMEOUT_EN
               if (wait_cnt_q == TimeoutLast) begin
                  winner_d  = WIN_PLAYER;
                  timeout_d = 1'b1;
                  state_d   = StDone;
               end
`endif
            end
         end
         StUserWait: begin
            if (user_valid && move_legal(board_q, user_action)) begin
               board_d[2*user_action +: 2] = CELL_PLAYER;
               action_d      = user_action;
               count_d       = count_q + 4'd1;
               agent_moved_d = 1'b0;
               state_d       = StCheck;
            end else begin
               illegal_d = user_valid;
`ifdef MOVE_TIMEOUT_EN
               if (wait_cnt_q == TimeoutLast) begin
                  winner_d  = WIN_AGENT;
                  timeout_d = 1'b1;
                  state_d   = StDone;
               end
`endif
            end
         end
         StCheck: begin
            if (mover_wins) begin
               winner_d = agent_moved_q ? WIN_AGENT : WIN_PLAYER;
               state_d  = StDone;
            end else if (count_q == 4'(NUM_CELLS)) begin
               winner_d = WIN_DRAW;
               state_d  = StDone;
            end else begin
               state_d = agent_moved_q ? StUserWait : StAgentWait;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state_q       <= StIdle;
         board_q       <= '0;
         action_q      <= '0;
         count_q       <= '0;
         winner_q      <= WIN_DRAW;
         illegal_q     <= 1'b0;
         agent_moved_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         board_q       <= board_d;
         action_q      <= action_d;
         count_q       <= count_d;
         winner_q      <= winner_d;
         illegal_q     <= illegal_d;
         agent_moved_q <= agent_moved_d;
      end
   end

`ifdef MOVE_TIMEOUT_EN
   always_ff @(posedge clock) begin
      if (rst) begin
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      agent_req = (state_q == StAgentWait);
      user_ready = (state_q == StUserWait);
      turn = agent_req ? TURN_AGENT : (user_ready ? TURN_PLAYER : TURN_NONE);
   end

   assign state_output  = board_q;
   assign action_output = action_q;
   assign move_count    = count_q;
   assign illegal       = illegal_q;
   assign game_over     = (state_q == StDone);
   assign winner        = winner_q;

endmodule

// File: tb/tb_ttt_game_sequencer.sv
// Directed self-checking bench for ttt_game_sequencer (AGENT_FIRST=1).
module tb_ttt_game_sequencer;

`ifdef MOVE_TIMEOUT_EN
   localparam int unsigned TO = 10;
`else
   localparam int unsigned TO = 255;
`endif

   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        agent_req;
   logic        agent_valid = 1'b0;
   logic [3:0]  agent_action = '0;
   logic        user_ready;
   logic        user_valid = 1'b0;
   logic [3:0]  user_action = '0;
   logic [17:0] state_output;
   logic [3:0]  action_output;
   logic [1:0]  turn;
   logic [3:0]  move_count;
   logic        illegal;
   logic        game_over;
   logic [1:0]  winner;
   logic        timeout;

   int n_checks = 0;
   int n_pass = 0;

   ttt_game_sequencer #(
      .AGENT_FIRST    (1'b1),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock         (clock),
      .rst           (rst),
      .start         (start),
      .agent_req     (agent_req),
      .agent_valid   (agent_valid),
      .agent_action  (agent_action),
      .user_ready    (user_ready),
      .user_valid    (user_valid),
      .user_action   (user_action),
      .state_output  (state_output),
      .action_output (action_output),
      .turn          (turn),
      .move_count    (move_count),
      .illegal       (illegal),
      .game_over     (game_over),
      .winner        (winner),
      .timeout       (timeout)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Advance until the named side is granted, bounded.
   task automatic wait_turn(input bit is_agent);
      int n;
      n = 0;
      while (!(is_agent ? agent_req : user_ready) && n < 20) begin
         step();
         n++;
      end
      check_eq(is_agent ? "agent_grant" : "user_grant",
               32'(is_agent ? agent_req : user_ready), 32'd1);
   endtask

   task automatic agent_move(input logic [3:0] a);
      wait_turn(1'b1);
      agent_valid = 1'b1;
      agent_action = a;
      step();
      agent_valid = 1'b0;
   endtask

   task automatic user_move(input logic [3:0] a);
      wait_turn(1'b0);
      user_valid = 1'b1;
      user_action = a;
      step();
      user_valid = 1'b0;
   endtask

   task automatic start_game();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_board"}, 32'(state_output), 32'd0);
      check_eq({tag, "_action"}, 32'(action_output), 32'd0);
      check_eq({tag, "_turn"}, 32'(turn), 32'd0);
      check_eq({tag, "_count"}, 32'(move_count), 32'd0);
      check_eq({tag, "_req_rdy"}, 32'({agent_req, user_ready}), 32'd0);
      check_eq({tag, "_ill_go"}, 32'({illegal, game_over}), 32'd0);
      check_eq({tag, "_winner"}, 32'(winner), 32'd0);
      check_eq({tag, "_timeout"}, 32'(timeout), 32'd0);
   endtask

   logic [3:0] draw_seq [9];

   initial begin
      draw_seq = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};

      // Reset state
      step();
      step();
      rst = 1'b0;
      check_all_zero("reset");

      // Game 1: agent wins on the top row
      start_game();
      check_eq("g1_req", 32'(agent_req), 32'd1);
      check_eq("g1_turn", 32'(turn), 32'd1);
      // User input outside its turn is ignored
      user_valid = 1'b1;
      user_action = 4'd4;
      step();
      user_valid = 1'b0;
      check_eq("ign_illegal", 32'(illegal), 32'd0);
      check_eq("ign_board", 32'(state_output), 32'd0);
      check_eq("ign_req", 32'(agent_req), 32'd1);

      agent_move(4'd0);
      check_eq("chk_req", 32'({agent_req, user_ready}), 32'd0);
      check_eq("chk_turn", 32'(turn), 32'd0);
      check_eq("m1_board", 32'(state_output), 32'h00001);
      check_eq("m1_count", 32'(move_count), 32'd1);
      step();
      check_eq("lat_ready", 32'(user_ready), 32'd1);
      check_eq("lat_turn", 32'(turn), 32'd2);
      // start mid-game is ignored
      start_game();
      check_eq("mid_start_cnt", 32'(move_count), 32'd1);
      check_eq("mid_start_rdy", 32'(user_ready), 32'd1);

      user_move(4'd3);
      check_eq("m2_board", 32'(state_output), 32'h00081);
      check_eq("m2_action", 32'(action_output), 32'd3);
      agent_move(4'd1);
      user_move(4'd4);
      agent_move(4'd2);
      check_eq("m5_go_early", 32'(game_over), 32'd0);
      step();
      check_eq("win_go", 32'(game_over), 32'd1);
      check_eq("win_winner", 32'(winner), 32'd1);
      check_eq("win_count", 32'(move_count), 32'd5);
      check_eq("win_board", 32'(state_output), 32'h00295);
      check_eq("win_turn", 32'(turn), 32'd0);
      step();
      check_eq("done_hold", 32'(state_output), 32'h00295);

      // Game 2: restart from DONE, then illegal moves
      start_game();
      check_eq("g2_board", 32'(state_output), 32'd0);
      check_eq("g2_count", 32'(move_count), 32'd0);
      check_eq("g2_winner", 32'(winner), 32'd0);
      check_eq("g2_go", 32'(game_over), 32'd0);
      agent_move(4'd4);
      user_move(4'd0);
      check_eq("g2_board2", 32'(state_output), 32'h00102);
      wait_turn(1'b1);
      agent_valid = 1'b1;
      agent_action = 4'd0;
      step();
      agent_valid = 1'b0;
      check_eq("occ_illegal", 32'(illegal), 32'd1);
      check_eq("occ_board", 32'(state_output), 32'h00102);
      check_eq("occ_req", 32'(agent_req), 32'd1);
      check_eq("occ_count", 32'(move_count), 32'd2);
      step();
      check_eq("occ_pulse_end", 32'(illegal), 32'd0);
      agent_valid = 1'b1;
      agent_action = 4'd9;
      step();
      agent_valid = 1'b0;
      check_eq("oob_illegal", 32'(illegal), 32'd1);
      check_eq("oob_board", 32'(state_output), 32'h00102);
      check_eq("oob_req", 32'(agent_req), 32'd1);
      agent_move(4'd8);
      check_eq("after_ill_board", 32'(state_output), 32'h10102);
      check_eq("after_ill_count", 32'(move_count), 32'd3);
      check_eq("after_ill_pulse", 32'(illegal), 32'd0);

      // Reset while the user is waiting
      wait_turn(1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_all_zero("midrst");

      // Game 3: full-board draw, no early DONE
      start_game();
      for (int i = 0; i < 9; i++) begin
         if (i % 2 == 0) agent_move(draw_seq[i]);
         else user_move(draw_seq[i]);
         step();
         if (i < 8) check_eq("draw_early", 32'(game_over), 32'd0);
      end
      check_eq("draw_go", 32'(game_over), 32'd1);
      check_eq("draw_count", 32'(move_count), 32'd9);
      check_eq("draw_winner", 32'(winner), 32'd0);
      check_eq("draw_board", 32'(state_output), 32'h16A59);
      check_eq("draw_timeout", 32'(timeout), 32'd0);

`ifdef MOVE_TIMEOUT_EN
      // User idles: forfeit after exactly TO wait cycles
      start_game();
      agent_move(4'd0);
      step();
      check_eq("to_ready", 32'(user_ready), 32'd1);
      for (int i = 1; i < 10; i++) begin
         step();
         check_eq("to_wait", 32'({game_over, user_ready}), 32'b01);
      end
      step();
      check_eq("to_go", 32'(game_over), 32'd1);
      check_eq("to_winner", 32'(winner), 32'd1);
      check_eq("to_flag", 32'(timeout), 32'd1);
      // Legal move in the final cycle wins over the timeout
      start_game();
      check_eq("to_cleared", 32'(timeout), 32'd0);
      agent_move(4'd0);
      step();
      for (int i = 1; i < 10; i++) step();
      user_valid = 1'b1;
      user_action = 4'd4;
      step();
      user_valid = 1'b0;
      check_eq("to_late_count", 32'(move_count), 32'd2);
      check_eq("to_late_flag", 32'(timeout), 32'd0);
      check_eq("to_late_go", 32'(game_over), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
